// File: rtl/ocp_burst_wr_slave_pkg.sv
// Shared encodings for the OCP burst write slave: command and response codes
// on the OCP side and the write-FSM state type.
package ocp_pkg;

    localparam int OCP_BLEN_W = 4;

    localparam logic [2:0] OCP_IDLE = 3'b000;
    localparam logic [2:0] OCP_WR   = 3'b001;
    localparam logic [2:0] OCP_RD   = 3'b010;

    localparam logic [1:0] OCP_NULL = 2'b00;
    localparam logic [1:0] OCP_DVA  = 2'b01;
    localparam logic [1:0] OCP_ERR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_RESP  = 2'd2
    } ocp_wr_state_t;

endpackage

// File: rtl/ocp_burst_wr_slave_if.sv
// OCP request/response bundle between a write master and ocp_burst_wr_slave.
interface ocp_burst_wr_slave_if
    import ocp_pkg::*;
#(
    parameter int Width = 32,
    parameter int AddrW = 4
);

    logic [2:0]            MCmd;
    logic [AddrW-1:0]      MAddr;
    logic [Width-1:0]      MData;
    logic [OCP_BLEN_W-1:0] MBurstLength;
    logic                  SCmdAccept;
    logic [1:0]            SResp;

    modport master (
        output MCmd, MAddr, MData, MBurstLength,
        input  SCmdAccept, SResp
    );

    modport slave (
        input  MCmd, MAddr, MData, MBurstLength,
        output SCmdAccept, SResp
    );

endinterface

// File: rtl/ocp_burst_wr_slave_beat_cnt.sv
// Beat counter for ocp_burst_wr_slave: next beat address, remaining beats
// and the last-beat flag. Loaded on a burst's first beat, stepped per beat.
module ocp_beat_cnt
    import ocp_pkg::*;
#(
    parameter int AddrW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [AddrW-1:0]      load_addr,
    input  logic [OCP_BLEN_W-1:0] load_len,
    output logic [AddrW-1:0]      addr,
    output logic                  last
);

    logic [AddrW-1:0]      addr_r;
    logic [OCP_BLEN_W-1:0] remaining_r;

    // Address holds the beat that comes next; the increment wraps modulo 2**AddrW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r      <= {AddrW{1'b0}};
            remaining_r <= {OCP_BLEN_W{1'b0}};
        end else if (load) begin
            addr_r      <= load_addr + {{(AddrW-1){1'b0}}, 1'b1};
            remaining_r <= load_len - {{(OCP_BLEN_W-1){1'b0}}, 1'b1};
        end else if (step) begin
            addr_r      <= addr_r + {{(AddrW-1){1'b0}}, 1'b1};
            remaining_r <= remaining_r - {{(OCP_BLEN_W-1){1'b0}}, 1'b1};
        end else begin
            addr_r      <= addr_r;
            remaining_r <= remaining_r;
        end
    end

    assign addr = addr_r;
    assign last = (remaining_r == {{(OCP_BLEN_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/ocp_burst_wr_slave.sv
// OCP burst write slave feeding a bank of 2**AddrW registers through one-hot
// load enables. Define OCP_BURST_WRAP_EN to let bursts wrap past the top address.
module ocp_burst_wr_slave
    import ocp_pkg::*;
#(
    parameter int Width    = 32,
    parameter int AddrW    = 4,
    parameter int MaxBurst = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ocp_burst_wr_slave_if.slave   bus,
    output logic [2**AddrW-1:0]   reg_ld,
    output logic [Width-1:0]      reg_d,
    output logic                  reg_sclr
);

    localparam int NumRegs = 2**AddrW;

    ocp_wr_state_t         state_r;
    ocp_wr_state_t         state_s;
    logic                  accept_r;
    logic [1:0]            resp_r;
    logic [1:0]            resp_s;
    logic [NumRegs-1:0]    ld_r;
    logic [Width-1:0]      d_r;
    logic                  sclr_r;

    logic                  write_s;
    logic                  load_s;
    logic                  step_s;
    logic [AddrW-1:0]      beat_addr_s;
    logic [AddrW-1:0]      cnt_addr_s;
    logic                  cnt_last_s;
    logic                  len_ok_s;
    logic                  range_ok_s;
    logic                  first_ok_s;

    function automatic logic [NumRegs-1:0] onehot(input logic [AddrW-1:0] a);
        logic [NumRegs-1:0] v;
        v = {NumRegs{1'b0}};
        for (int i = 0; i < NumRegs; i++) begin
            v[i] = (a == AddrW'(i));
        end
        return v;
    endfunction

    ocp_beat_cnt #(
        .AddrW (AddrW)
    ) u_beat_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .step      (step_s),
        .load_addr (bus.MAddr),
        .load_len  (bus.MBurstLength),
        .addr      (cnt_addr_s),
        .last      (cnt_last_s)
    );

    assign len_ok_s = (bus.MBurstLength != {OCP_BLEN_W{1'b0}}) &&
                      (bus.MBurstLength <= OCP_BLEN_W'(MaxBurst));
`ifdef OCP_BURST_WRAP_EN
    assign range_ok_s = 1'b1;
`else
    // A burst must fit between its start address and the top of the bank.
    assign range_ok_s = (32'(bus.MAddr) + 32'(bus.MBurstLength)) <= 32'(NumRegs);
`endif
    assign first_ok_s = (bus.MCmd == OCP_WR) && len_ok_s && range_ok_s;

    // Write FSM: next state, beat strobes and the response code for RESP.
    always_comb begin
        state_s     = state_r;
        write_s     = 1'b0;
        load_s      = 1'b0;
        step_s      = 1'b0;
        beat_addr_s = cnt_addr_s;
        resp_s      = OCP_NULL;
        case (state_r)
            S_IDLE: begin
                if (!accept_r) begin
                    state_s = S_IDLE;
                end else if (first_ok_s) begin
                    write_s     = 1'b1;
                    load_s      = 1'b1;
                    beat_addr_s = bus.MAddr;
                    if (bus.MBurstLength == {{(OCP_BLEN_W-1){1'b0}}, 1'b1}) begin
                        state_s = S_RESP;
                        resp_s  = OCP_DVA;
                    end else begin
                        state_s = S_BURST;
                    end
                end else if (bus.MCmd == OCP_IDLE) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_RESP;
                    resp_s  = OCP_ERR;
                end
            end
            S_BURST: begin
                case (bus.MCmd)
                    OCP_WR: begin
                        write_s = 1'b1;
                        step_s  = 1'b1;
                        if (cnt_last_s) begin
                            state_s = S_RESP;
                            resp_s  = OCP_DVA;
                        end else begin
                            state_s = S_BURST;
                        end
                    end
                    OCP_IDLE: begin
                        state_s = S_BURST;
                    end
                    default: begin
                        state_s = S_RESP;
                        resp_s  = OCP_ERR;
                    end
                endcase
            end
            S_RESP: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered bus handshake; acceptance drops exactly for the RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accept_r <= 1'b0;
            resp_r   <= OCP_NULL;
            sclr_r   <= 1'b1;
        end else begin
            accept_r <= (state_s != S_RESP);
            resp_r   <= resp_s;
            sclr_r   <= 1'b0;
        end
    end

    // Register-bank drive: one load pulse per accepted beat, data held between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_r <= {NumRegs{1'b0}};
            d_r  <= {Width{1'b0}};
        end else if (write_s) begin
            ld_r <= onehot(beat_addr_s);
            d_r  <= bus.MData;
        end else begin
            ld_r <= {NumRegs{1'b0}};
            d_r  <= d_r;
        end
    end

    assign bus.SCmdAccept = accept_r;
    assign bus.SResp      = resp_r;
    assign reg_ld         = ld_r;
    assign reg_d          = d_r;
    assign reg_sclr       = sclr_r;

endmodule

// File: tb/tb_ocp_burst_wr_slave.sv
// Bench for ocp_burst_wr_slave: burst-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ocp_burst_wr_slave;

    localparam int W  = 32;
    localparam int AW = 4;
    localparam int NR = 16;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] reg_ld;
    logic [W-1:0]  reg_d;
    logic          reg_sclr;

    ocp_burst_wr_slave_if #(.Width(W), .AddrW(AW)) bus_if ();

    ocp_burst_wr_slave #(.Width(W), .AddrW(AW), .MaxBurst(MB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .reg_ld   (reg_ld),
        .reg_d    (reg_d),
        .reg_sclr (reg_sclr)
    );

    always #5 clk = ~clk;

    // Downstream register bank as the DUT sees it.
    logic [W-1:0] r_bank [NR];
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (reg_sclr) r_bank[i] <= '0;
            else if (reg_ld[i]) r_bank[i] <= reg_d;
        end
    end

    // Model state: burst progress plus expected outputs for the current cycle.
    int            beats_left;
    int            nxt_addr;
    logic [NR-1:0] exp_ld;
    logic [W-1:0]  exp_d;
    logic [1:0]    exp_resp;
    logic          exp_accept;
    logic          exp_sclr;
    logic [W-1:0]  mreg [NR];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            ld_pulses = 0;
    bit            chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        beats_left = 0;
        nxt_addr   = 0;
        exp_ld     = '0;
        exp_d      = '0;
        exp_resp   = 2'b00;
        exp_accept = 1'b0;
        exp_sclr   = 1'b1;
        for (int i = 0; i < NR; i++) mreg[i] = '0;
    endtask

    task automatic model_write(input int a, input logic [W-1:0] d);
        exp_ld    = '0;
        exp_ld[a] = 1'b1;
        exp_d     = d;
        mreg[a]   = d;
    endtask

    function automatic bit fits(input int a, input int len);
`ifdef OCP_BURST_WRAP_EN
        return 1'b1;
`else
        return (a + len) <= NR;
`endif
    endfunction

    // One clock edge of the spec's rules applied to the inputs just sampled.
    task automatic model_step();
        logic acc;
        int cmd, len, a;
        acc = exp_accept;
        cmd = int'(bus_if.MCmd);
        len = int'(bus_if.MBurstLength);
        a   = int'(bus_if.MAddr);
        exp_ld   = '0;
        exp_resp = 2'b00;
        exp_sclr = 1'b0;
        if (acc) begin
            if (beats_left == 0) begin
                if (cmd == 1 && len >= 1 && len <= MB && fits(a, len)) begin
                    model_write(a, bus_if.MData);
                    beats_left = len - 1;
                    nxt_addr   = (a + 1) % NR;
                    if (beats_left == 0) exp_resp = 2'b01;
                end else if (cmd != 0) begin
                    exp_resp = 2'b11;
                end
            end else begin
                if (cmd == 1) begin
                    model_write(nxt_addr, bus_if.MData);
                    nxt_addr = (nxt_addr + 1) % NR;
                    beats_left--;
                    if (beats_left == 0) exp_resp = 2'b01;
                end else if (cmd != 0) begin
                    exp_resp   = 2'b11;
                    beats_left = 0;
                end
            end
        end
        exp_accept = (exp_resp == 2'b00);
    endtask

    task automatic drive(input int cmd, input int a, input logic [W-1:0] d, input int len);
        bus_if.MCmd         = 3'(cmd);
        bus_if.MAddr        = 4'(a);
        bus_if.MData        = d;
        bus_if.MBurstLength = 4'(len);
        @(posedge clk);
        #1;
        if (rst_n) model_step();
        else model_reset();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, '0, 0);
    endtask

    // Hold a command until the model says it was accepted (bounded).
    task automatic send(input int cmd, input int a, input logic [W-1:0] d, input int len,
                        output int tries);
        logic acc;
        tries = 0;
        do begin
            acc = exp_accept;
            drive(cmd, a, d, len);
            tries++;
        end while (!acc && tries < 4);
        if (!acc) chk("send_accept", {31'b0, acc}, 32'd1);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("SCmdAccept", {31'b0, bus_if.SCmdAccept}, {31'b0, exp_accept});
            chk("SResp", {30'b0, bus_if.SResp}, {30'b0, exp_resp});
            chk("reg_ld", {16'b0, reg_ld}, {16'b0, exp_ld});
            chk("reg_sclr", {31'b0, reg_sclr}, {31'b0, exp_sclr});
            chk("reg_ld_onehot0", {31'b0, $onehot0(reg_ld)}, 32'd1);
            if (exp_ld != '0) chk("reg_d", reg_d, exp_d);
            if (reg_ld != '0) ld_pulses++;
        end
    end

    initial begin
        int t;
        int p0;
        int r;
        bus_if.MCmd = 3'd0; bus_if.MAddr = '0; bus_if.MData = '0; bus_if.MBurstLength = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        idle(3);
        chk("rst_sclr", {31'b0, reg_sclr}, 32'd1);
        chk("rst_accept", {31'b0, bus_if.SCmdAccept}, 32'd0);
        chk("rst_ld", {16'b0, reg_ld}, 32'd0);
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_accept", {31'b0, bus_if.SCmdAccept}, 32'd1);
        chk("post_rst_sclr", {31'b0, reg_sclr}, 32'd0);
        idle(1);

        // Single write
        send(1, 3, 32'd34, 1, t);
        chk("single_ld", {16'b0, reg_ld}, 32'h0008);
        chk("single_d", reg_d, 32'd34);
        chk("single_dva", {30'b0, bus_if.SResp}, 32'd1);
        chk("single_resp_accept", {31'b0, bus_if.SCmdAccept}, 32'd0);
        idle(1);
        chk("single_resp_done", {30'b0, bus_if.SResp}, 32'd0);
        idle(1);
        chk("single_R3", r_bank[3], 32'd34);

        // Burst of 4 with one stall; non-first beats carry junk addr/len
        send(1, 2, 32'd10, 4, t);
        chk("burst_no_early_resp", {30'b0, bus_if.SResp}, 32'd0);
        drive(1, 9, 32'd11, 7);
        drive(0, 0, '0, 0);
        drive(1, 1, 32'd12, 1);
        chk("burst_mid_resp", {30'b0, bus_if.SResp}, 32'd0);
        drive(1, 0, 32'd13, 0);
        chk("burst_dva", {30'b0, bus_if.SResp}, 32'd1);
        chk("burst_last_ld", {16'b0, reg_ld}, 32'h0020);
        idle(2);
        for (int i = 0; i < 4; i++) chk("burst_R", r_bank[2+i], 32'(10 + i));

        // Wrap at the top of the bank
        send(1, 14, 32'd20, 4, t);
`ifdef OCP_BURST_WRAP_EN
        drive(1, 0, 32'd21, 0);
        drive(1, 0, 32'd22, 0);
        drive(1, 0, 32'd23, 0);
        chk("wrap_dva", {30'b0, bus_if.SResp}, 32'd1);
        chk("wrap_ld_r1", {16'b0, reg_ld}, 32'h0002);
        idle(2);
        chk("wrap_R14", r_bank[14], 32'd20);
        chk("wrap_R15", r_bank[15], 32'd21);
        chk("wrap_R0", r_bank[0], 32'd22);
        chk("wrap_R1", r_bank[1], 32'd23);
`else
        chk("wrap_no_ld", {16'b0, reg_ld}, 32'd0);
        chk("wrap_err", {30'b0, bus_if.SResp}, 32'd3);
        idle(2);
        chk("wrap_R14", r_bank[14], 32'd0);
        chk("wrap_R0", r_bank[0], 32'd0);
`endif

        // Error cases
        send(1, 0, 32'd99, 0, t);
        chk("len0_err", {30'b0, bus_if.SResp}, 32'd3);
        chk("err_accept", {31'b0, bus_if.SCmdAccept}, 32'd0);
        idle(1);
        send(1, 1, 32'd98, 9, t);
        chk("len9_err", {30'b0, bus_if.SResp}, 32'd3);
        idle(1);
        send(2, 4, 32'd97, 1, t);
        chk("rd_idle_err", {30'b0, bus_if.SResp}, 32'd3);
        idle(1);
        send(1, 8, 32'd55, 3, t);
        drive(2, 0, 32'd56, 0);
        chk("rd_burst_err", {30'b0, bus_if.SResp}, 32'd3);
        chk("rd_burst_no_ld", {16'b0, reg_ld}, 32'd0);
        idle(2);
        chk("abort_R8", r_bank[8], 32'd55);
        chk("abort_R9", r_bank[9], 32'd0);

        // Back-to-back len-2 bursts
        p0 = ld_pulses;
        send(1, 6, 32'd60, 2, t);
        send(1, 0, 32'd61, 0, t);
        send(1, 10, 32'd62, 2, t);
        chk("b2b_resp_gap", 32'(t), 32'd2);
        send(1, 0, 32'd63, 0, t);
        idle(2);
        chk("b2b_pulses", 32'(ld_pulses - p0), 32'd4);
        chk("b2b_R6", r_bank[6], 32'd60);
        chk("b2b_R7", r_bank[7], 32'd61);
        chk("b2b_R10", r_bank[10], 32'd62);
        chk("b2b_R11", r_bank[11], 32'd63);

        // Reset in the middle of a burst, after beat 2 of 4
        send(1, 0, 32'd70, 4, t);
        drive(1, 0, 32'd71, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_ld", {16'b0, reg_ld}, 32'd0);
        chk("midrst_resp", {30'b0, bus_if.SResp}, 32'd0);
        chk("midrst_accept", {31'b0, bus_if.SCmdAccept}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(4);
        chk("midrst_R0", r_bank[0], 32'd0);
        chk("midrst_R1", r_bank[1], 32'd0);
        chk("midrst_R6", r_bank[6], 32'd0);

        // Randomized traffic
        repeat (400) begin
            r = $urandom_range(0, 9);
            if (r <= 5) t = 1;
            else if (r <= 7) t = 0;
            else if (r == 8) t = 2;
            else t = $urandom_range(3, 7);
            drive(t, $urandom_range(0, 15), $urandom,
                  ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8));
        end
        idle(3);
        for (int i = 0; i < NR; i++) chk("final_bank", r_bank[i], mreg[i]);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
